// File: rtl/multi_user_authenticator.sv
// Purpose: multi-user login front-end that takes an ID and a multi-digit password, with timed lockout and optional idle logout.
// Latency: press pulse 3 cycles after raw button rise; state and outputs registered 1 cycle after press/logout/timeout.
// Backpressure: none; at most one press per button push, presses in LOCKED or on a state-exit cycle are dropped.
// Ports: clk, rst (synchronous, active-high); PasswordSwitch/PasswordButton operator inputs;
//        LogoutCommand_from_GC, Activity_from_GC from the game controller; LoggedOut/LoggedIn/Locked status,
//        isGuest_to_GC/PlayerAddress_to_GC session info, AttemptsLeft wrong-password budget.
module multi_user_authenticator #(
    parameter int SW_W         = 4,
    parameter int NUM_USERS    = 4,
    parameter int PW_DIGITS    = 2,
    parameter int ADDR_W       = 5,
    parameter int MAX_TRIES    = 3,
    parameter int LOCK_CYCLES  = 16,
    parameter int IDLE_TIMEOUT = 0,
    parameter logic [SW_W-1:0]                     GUEST_ID = 4'hF,
    parameter logic [NUM_USERS*SW_W-1:0]           ID_TABLE = {4'h4, 4'h3, 4'h2, 4'h1},
    parameter logic [NUM_USERS*PW_DIGITS*SW_W-1:0] PW_TABLE = {8'h00, 8'h77, 8'h21, 8'hA5},
    localparam int AW = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   PasswordSwitch,
    input  logic              PasswordButton,
    input  logic              LogoutCommand_from_GC,
    input  logic              Activity_from_GC,
    output logic              LoggedOut,
    output logic              LoggedIn,
    output logic              isGuest_to_GC,
    output logic [ADDR_W-1:0] PlayerAddress_to_GC,
    output logic              Locked,
    output logic [AW-1:0]     AttemptsLeft
);

    localparam int PW_W = PW_DIGITS * SW_W;
    localparam int DW   = (PW_DIGITS > 1) ? $clog2(PW_DIGITS) : 1;
    localparam int LW   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int IW   = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    generate
        if (NUM_USERS >= (1 << ADDR_W)) begin : g_bad_addr_w
            $error("NUM_USERS must be smaller than 2**ADDR_W");
        end
        if (MAX_TRIES < 1 || LOCK_CYCLES < 1 || PW_DIGITS < 1) begin : g_bad_counts
            $error("MAX_TRIES, LOCK_CYCLES and PW_DIGITS must all be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_GET_PW, S_LOGGED_IN, S_LOCKED} state_t;

    state_t            r_state, w_state_nx;
    logic              r_btn_s1, r_btn_s2, r_btn_s3, r_press;
    logic [ADDR_W-1:0] r_user, w_user_nx;
    logic [DW-1:0]     r_digit_cnt, w_digit_cnt_nx;
    logic [PW_W-1:0]   r_digits, w_digits_nx;
    logic [AW-1:0]     r_attempts, w_attempts_nx;
    logic [LW-1:0]     r_lock_cnt, w_lock_cnt_nx;
    logic [IW-1:0]     r_idle_cnt, w_idle_cnt_nx;
    logic              r_guest, w_guest_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic              r_logged_in, r_logged_out, r_locked;
    logic              w_id_hit;
    logic [ADDR_W-1:0] w_id_idx;
    logic [PW_W-1:0]   w_pw_exp, w_pw_entered;
    logic              w_last_digit;

    // ID lookup; scanning downwards leaves the lowest matching index.
    always_comb begin
        w_id_hit = 1'b0;
        w_id_idx = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if (ID_TABLE[i*SW_W +: SW_W] == PasswordSwitch) begin
                w_id_hit = 1'b1;
                w_id_idx = ADDR_W'(i);
            end
        end
    end

    // Stored password of the latched user.
    always_comb begin
        w_pw_exp = '0;
        for (int i = 0; i < NUM_USERS; i++) begin
            if (r_user == ADDR_W'(i)) w_pw_exp = PW_TABLE[i*PW_W +: PW_W];
        end
    end

    // Digits entered so far with the switch value merged into the current slot.
    always_comb begin
        w_pw_entered = r_digits;
        for (int d = 0; d < PW_DIGITS; d++) begin
            if (r_digit_cnt == DW'(d)) w_pw_entered[d*SW_W +: SW_W] = PasswordSwitch;
        end
    end

    assign w_last_digit = (r_digit_cnt == DW'(PW_DIGITS - 1));

    always_comb begin
        w_state_nx     = r_state;
        w_user_nx      = r_user;
        w_digit_cnt_nx = r_digit_cnt;
        w_digits_nx    = r_digits;
        w_attempts_nx  = r_attempts;
        w_lock_cnt_nx  = r_lock_cnt;
        w_idle_cnt_nx  = r_idle_cnt;
        w_guest_nx     = r_guest;
        w_addr_nx      = r_addr;
        case (r_state)
            S_IDLE: begin
                if (!LogoutCommand_from_GC && r_press) begin
                    if (PasswordSwitch == GUEST_ID) begin
                        w_state_nx    = S_LOGGED_IN;
                        w_guest_nx    = 1'b1;
                        w_addr_nx     = ADDR_W'(NUM_USERS);
                        w_idle_cnt_nx = '0;
                    end else if (w_id_hit) begin
                        w_state_nx     = S_GET_PW;
                        w_user_nx      = w_id_idx;
                        w_digit_cnt_nx = '0;
                        w_digits_nx    = '0;
                    end
                end
            end
            S_GET_PW: begin
                if (LogoutCommand_from_GC) begin
                    w_state_nx     = S_IDLE;
                    w_digit_cnt_nx = '0;
                    w_digits_nx    = '0;
                end else if (r_press) begin
                    if (w_last_digit) begin
                        w_digit_cnt_nx = '0;
                        w_digits_nx    = '0;
                        if (w_pw_entered == w_pw_exp) begin
                            w_state_nx    = S_LOGGED_IN;
                            w_attempts_nx = AW'(MAX_TRIES);
                            w_guest_nx    = 1'b0;
                            w_addr_nx     = r_user;
                            w_idle_cnt_nx = '0;
                        end else if (r_attempts > AW'(1)) begin
                            w_state_nx    = S_IDLE;
                            w_attempts_nx = r_attempts - AW'(1);
                        end else begin
                            w_state_nx    = S_LOCKED;
                            w_attempts_nx = '0;
                            w_lock_cnt_nx = LW'(LOCK_CYCLES - 1);
                        end
                    end else begin
                        w_digits_nx    = w_pw_entered;
                        w_digit_cnt_nx = r_digit_cnt + DW'(1);
                    end
                end
            end
            S_LOGGED_IN: begin
                if (LogoutCommand_from_GC) begin
                    w_state_nx = S_IDLE;
                    w_guest_nx = 1'b0;
                    w_addr_nx  = '0;
                end else if (IDLE_TIMEOUT > 0) begin
                    // Activity on the timeout cycle keeps the session alive.
                    if (Activity_from_GC || r_press) begin
                        w_idle_cnt_nx = '0;
                    end else if (r_idle_cnt == IW'(IDLE_TIMEOUT)) begin
                        w_state_nx    = S_IDLE;
                        w_guest_nx    = 1'b0;
                        w_addr_nx     = '0;
                        w_idle_cnt_nx = '0;
                    end else begin
                        w_idle_cnt_nx = r_idle_cnt + IW'(1);
                    end
                end
            end
            S_LOCKED: begin
                if (r_lock_cnt == '0) begin
                    w_state_nx    = S_IDLE;
                    w_attempts_nx = AW'(MAX_TRIES);
                end else begin
                    w_lock_cnt_nx = r_lock_cnt - LW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_s1     <= 1'b0;
            r_btn_s2     <= 1'b0;
            r_btn_s3     <= 1'b0;
            r_press      <= 1'b0;
            r_state      <= S_IDLE;
            r_user       <= '0;
            r_digit_cnt  <= '0;
            r_digits     <= '0;
            r_attempts   <= AW'(MAX_TRIES);
            r_lock_cnt   <= '0;
            r_idle_cnt   <= '0;
            r_guest      <= 1'b0;
            r_addr       <= '0;
            r_logged_in  <= 1'b0;
            r_logged_out <= 1'b1;
            r_locked     <= 1'b0;
        end else begin
            r_btn_s1     <= PasswordButton;
            r_btn_s2     <= r_btn_s1;
            r_btn_s3     <= r_btn_s2;
            r_press      <= r_btn_s2 & ~r_btn_s3;
            r_state      <= w_state_nx;
            r_user       <= w_user_nx;
            r_digit_cnt  <= w_digit_cnt_nx;
            r_digits     <= w_digits_nx;
            r_attempts   <= w_attempts_nx;
            r_lock_cnt   <= w_lock_cnt_nx;
            r_idle_cnt   <= w_idle_cnt_nx;
            r_guest      <= w_guest_nx;
            r_addr       <= w_addr_nx;
            r_logged_in  <= (w_state_nx == S_LOGGED_IN);
            r_logged_out <= (w_state_nx != S_LOGGED_IN);
            r_locked     <= (w_state_nx == S_LOCKED);
        end
    end

    assign LoggedOut           = r_logged_out;
    assign LoggedIn            = r_logged_in;
    assign isGuest_to_GC       = r_guest;
    assign PlayerAddress_to_GC = r_addr;
    assign Locked              = r_locked;
    assign AttemptsLeft        = r_attempts;

endmodule

// File: tb/tb_multi_user_authenticator.sv
// Purpose: randomized and directed stimulus against a behavioural login model.
// Latency: outputs compared every cycle on the falling edge.
// Backpressure: none.
module tb_multi_user_authenticator;

    localparam int NUM_USERS = 4;
    localparam int PW_DIGITS = 2;
    localparam int MAX_TRIES = 3;
    localparam int LOCK_CYC  = 16;
    localparam int IDLE_TO   = 10;
    localparam int GUEST     = 15;
    localparam logic [15:0] ID_TAB = 16'h4321;
    localparam logic [31:0] PW_TAB = 32'h0077_21A5;

    localparam int M_IDLE = 0, M_PW = 1, M_IN = 2, M_LOCK = 3;

    logic       clk = 1'b0;
    logic       rst, btn, lo, act;
    logic [3:0] sw;
    logic       LoggedOut, LoggedIn, isGuest_to_GC, Locked;
    logic [4:0] PlayerAddress_to_GC;
    logic [1:0] AttemptsLeft;

    int n_vec = 0;
    int n_err = 0;
    bit g_noise = 1'b0;

    multi_user_authenticator #(.IDLE_TIMEOUT(IDLE_TO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .PasswordSwitch        (sw),
        .PasswordButton        (btn),
        .LogoutCommand_from_GC (lo),
        .Activity_from_GC      (act),
        .LoggedOut             (LoggedOut),
        .LoggedIn              (LoggedIn),
        .isGuest_to_GC         (isGuest_to_GC),
        .PlayerAddress_to_GC   (PlayerAddress_to_GC),
        .Locked                (Locked),
        .AttemptsLeft          (AttemptsLeft)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mode, m_user, m_att, m_guest, m_addr, m_cyc, m_lock_end, m_last_act;
    int m_dig[$];
    bit h1, h2, h3, h4;   // raw button as sampled 1..4 edges ago

    function automatic int id_of(input int u);
        return int'((ID_TAB >> (u * 4)) & 16'hF);
    endfunction

    function automatic int pw_of(input int u, input int d);
        return int'((PW_TAB >> ((u * PW_DIGITS + d) * 4)) & 32'hF);
    endfunction

    task automatic model_step(input bit r, input bit b, input int s, input bit l, input bit a);
        bit pr;
        bit ok;
        int hit;
        m_cyc++;
        pr = h3 & ~h4;
        if (r) begin
            {h1, h2, h3, h4} = 4'b0;
            m_mode = M_IDLE; m_att = MAX_TRIES; m_guest = 0; m_addr = 0;
            m_dig.delete();
            return;
        end
        h4 = h3; h3 = h2; h2 = h1; h1 = b;
        case (m_mode)
            M_IDLE: if (!l && pr) begin
                if (s == GUEST) begin
                    m_mode = M_IN; m_guest = 1; m_addr = NUM_USERS; m_last_act = m_cyc;
                end else begin
                    hit = -1;
                    for (int u = NUM_USERS - 1; u >= 0; u--) if (id_of(u) == s) hit = u;
                    if (hit >= 0) begin
                        m_mode = M_PW; m_user = hit; m_dig.delete();
                    end
                end
            end
            M_PW: if (l) begin
                m_mode = M_IDLE; m_dig.delete();
            end else if (pr) begin
                m_dig.push_back(s);
                if (m_dig.size() == PW_DIGITS) begin
                    ok = 1;
                    for (int d = 0; d < PW_DIGITS; d++) if (m_dig[d] != pw_of(m_user, d)) ok = 0;
                    m_dig.delete();
                    if (ok) begin
                        m_att = MAX_TRIES; m_mode = M_IN; m_guest = 0; m_addr = m_user;
                        m_last_act = m_cyc;
                    end else if (m_att > 1) begin
                        m_att--; m_mode = M_IDLE;
                    end else begin
                        m_att = 0; m_mode = M_LOCK; m_lock_end = m_cyc + LOCK_CYC;
                    end
                end
            end
            M_IN: if (l) begin
                m_mode = M_IDLE; m_guest = 0; m_addr = 0;
            end else if (a || pr) begin
                m_last_act = m_cyc;
            end else if (m_cyc - m_last_act > IDLE_TO) begin
                m_mode = M_IDLE; m_guest = 0; m_addr = 0;
            end
            M_LOCK: if (m_cyc == m_lock_end) begin
                m_mode = M_IDLE; m_att = MAX_TRIES;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit r, input bit b, input logic [3:0] s, input bit l, input bit a);
        rst = r; btn = b; sw = s; lo = l; act = a;
        model_step(r, b, int'(s), l, a);
        @(posedge clk);
        @(negedge clk);
        chk("m_LoggedIn",  int'(LoggedIn),            int'(m_mode == M_IN));
        chk("m_LoggedOut", int'(LoggedOut),           int'(m_mode != M_IN));
        chk("m_Locked",    int'(Locked),              int'(m_mode == M_LOCK));
        chk("m_isGuest",   int'(isGuest_to_GC),       m_guest);
        chk("m_Addr",      int'(PlayerAddress_to_GC), m_addr);
        chk("m_Attempts",  int'(AttemptsLeft),        m_att);
    endtask

    task automatic cyc_n(input bit b, input logic [3:0] s);
        bit l, a;
        l = 0; a = 0;
        if (g_noise) begin
            l = ($urandom_range(0, 29) == 0);
            a = ($urandom_range(0, 11) == 0);
        end
        cyc(1'b0, b, s, l, a);
    endtask

    task automatic press_op(input logic [3:0] s, input int hold, input int gap);
        repeat (hold) cyc_n(1'b1, s);
        repeat (gap)  cyc_n(1'b0, s);
    endtask

    task automatic press(input logic [3:0] s);
        press_op(s, 1, 4);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_LoggedOut"}, int'(LoggedOut), 1);
        chk({tag, "_LoggedIn"},  int'(LoggedIn), 0);
        chk({tag, "_isGuest"},   int'(isGuest_to_GC), 0);
        chk({tag, "_Addr"},      int'(PlayerAddress_to_GC), 0);
        chk({tag, "_Locked"},    int'(Locked), 0);
        chk({tag, "_Attempts"},  int'(AttemptsLeft), MAX_TRIES);
    endtask

    function automatic logic [3:0] pick_sw();
        int k;
        k = $urandom_range(0, 7);
        if (m_mode == M_PW && k < 6) return 4'(pw_of(m_user, m_dig.size()));
        if (m_mode != M_PW && k == 0) return 4'(GUEST);
        if (m_mode != M_PW && k < 6) return 4'(id_of($urandom_range(0, NUM_USERS - 1)));
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        int n, locked_n;
        bit seen;
        rst = 1'b1; btn = 1'b0; sw = 4'h0; lo = 1'b0; act = 1'b0;
        @(negedge clk);
        repeat (3) cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        idle(2);
        check_reset("rst");

        // basic user login and logout
        press(4'h1); press(4'h5); press(4'hA);
        chk("u0_in", int'(LoggedIn), 1);
        chk("u0_addr", int'(PlayerAddress_to_GC), 0);
        chk("u0_guest", int'(isGuest_to_GC), 0);
        chk("u0_att", int'(AttemptsLeft), 3);
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("u0_out", int'(LoggedOut), 1);
        chk("u0_out_addr", int'(PlayerAddress_to_GC), 0);

        // guest, then a long hold must count as a single press
        press(4'hF);
        chk("guest_in", int'(LoggedIn), 1);
        chk("guest_flag", int'(isGuest_to_GC), 1);
        chk("guest_addr", int'(PlayerAddress_to_GC), 4);
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        press_op(4'h1, 20, 4); press(4'h5); press(4'hA);
        chk("hold_in", int'(LoggedIn), 1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

        // three wrong passwords then lockout
        press(4'h2); press(4'h0); press(4'h0);
        chk("wrong1_att", int'(AttemptsLeft), 2);
        press(4'h2); press(4'h0); press(4'h0);
        chk("wrong2_att", int'(AttemptsLeft), 1);
        press(4'h2); press(4'h0);
        locked_n = 0; seen = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, (i % 3) == 0, 4'h0, 1'b0, 1'b0);
            if (Locked) begin
                locked_n++; seen = 1;
                chk("lock_att", int'(AttemptsLeft), 0);
            end else if (seen) break;
        end
        chk("lock_len", locked_n, LOCK_CYC);
        idle(4);
        chk("unlock_att", int'(AttemptsLeft), 3);
        chk("unlock_out", int'(LoggedOut), 1);

        // abort mid-password and unknown ID leave attempts alone
        press(4'h1); press(4'h0); press(4'h0);
        press(4'h3); press(4'h7);
        cyc(1'b0, 1'b0, 4'h7, 1'b1, 1'b0);
        chk("abort_att", int'(AttemptsLeft), 2);
        press(4'h9);
        chk("unk_att", int'(AttemptsLeft), 2);
        chk("unk_out", int'(LoggedOut), 1);
        press(4'h3); press(4'h7); press(4'h7);
        chk("u2_in", int'(LoggedIn), 1);
        chk("u2_addr", int'(PlayerAddress_to_GC), 2);
        chk("u2_att", int'(AttemptsLeft), 3);
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

        // idle timeout
        press(4'hF);
        idle(4);
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            idle(1);
            if (!LoggedIn) begin n = i; break; end
        end
        chk("idle_drop", n, IDLE_TO + 1);

        // logout and timeout on the same cycle
        press(4'hF);
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        idle(IDLE_TO);
        chk("pre_to_in", int'(LoggedIn), 1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("lo_to_out", int'(LoggedOut), 1);
        idle(1);
        chk("lo_to_stay", int'(LoggedOut), 1);

        // reset mid-password and mid-lockout
        press(4'h1); press(4'h5);
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        check_reset("rst_pw");
        repeat (3) begin press(4'h1); press(4'h0); press(4'h0); end
        chk("rst_lk_locked", int'(Locked), 1);
        idle(3);
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        check_reset("rst_lk");
        press(4'h1); press(4'h5); press(4'hA);
        chk("post_rst_in", int'(LoggedIn), 1);
        chk("post_rst_addr", int'(PlayerAddress_to_GC), 0);
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

        // randomized traffic
        g_noise = 1'b1;
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0: idle($urandom_range(5, 20));
                1: if ($urandom_range(0, 3) == 0) cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
                   else cyc_n(1'b0, 4'h0);
                default: press_op(pick_sw(), $urandom_range(1, 4), $urandom_range(1, 5));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
